// File: rtl/channel_sample_sequencer.sv
// rtl/channel_sample_sequencer.sv - round-robin sample write scheduler and full-channel drain arbiter
// Issues one buffer write per divided slot and hands one full channel at a time to the drain port.
module channel_sample_sequencer #(
  parameter int NUM_CHANNELS = 14,
  parameter int SAMPLE_BITS  = 8,
  parameter int DEPTH        = 10,
  parameter int DIVIDER      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_BITS-1:0]  sample_in,
  input  logic [NUM_CHANNELS-1:0] ch_en,
  output logic                    wr_valid,
  output logic [3:0]              wr_channel,
  output logic [SAMPLE_BITS-1:0]  wr_data,
  output logic                    drain_valid,
  input  logic                    drain_ready,
  output logic [3:0]              drain_channel,
  output logic [3:0]              drain_index,
  output logic                    drain_last,
  output logic [NUM_CHANNELS-1:0] ready_mask,
  output logic [7:0]              overrun_cnt
);

  localparam int DW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
  localparam logic [3:0] FILL_FULL = 4'(DEPTH);
  localparam logic [3:0] IDX_LAST  = 4'(DEPTH - 1);
  localparam logic [3:0] CH_LAST   = 4'(NUM_CHANNELS - 1);

  typedef enum logic {D_IDLE, D_XFER} drain_state_t;
  drain_state_t state, state_next;

  logic [DW-1:0] div_cnt;
  logic [3:0]    last_wr;
  logic [3:0]    last_gnt;
  logic [3:0]    fill [NUM_CHANNELS];
  logic          tick, xfer, wr_hit, wr_blocked, wr_commit, tgt_full, drain_done, gnt_hit;
  logic [3:0]    wr_tgt, gnt_tgt;

  // Returns {found, channel}: first set bit after 'last', wrapping; nearest candidate wins.
  function automatic logic [4:0] rr_pick(input logic [NUM_CHANNELS-1:0] mask, input logic [3:0] last);
    logic [4:0] pick;
    int idx;
    pick = '0;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_CHANNELS;
      if (mask[idx]) pick = {1'b1, idx[3:0]};
    end
    return pick;
  endfunction

  always_comb begin
    ready_mask = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ready_mask[i] = (fill[i] == FILL_FULL);
    end
  end

  always_comb begin
    tick               = enable && (div_cnt == DIV_LAST);
    xfer               = (state == D_XFER);
    {wr_hit, wr_tgt}   = rr_pick(ch_en, last_wr);
    {gnt_hit, gnt_tgt} = rr_pick(ready_mask, last_gnt);
    wr_blocked         = xfer && (wr_tgt == drain_channel);
    wr_commit          = tick && wr_hit && !wr_blocked;
    drain_done         = xfer && drain_ready && (drain_index == IDX_LAST);
    tgt_full           = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (wr_tgt == 4'(i)) tgt_full = ready_mask[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // A skipped write still advances the pointer; skips and full-channel writes both count as overruns.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid    <= 1'b0;
      wr_channel  <= '0;
      wr_data     <= '0;
      last_wr     <= CH_LAST;
      overrun_cnt <= '0;
    end else begin
      wr_valid <= wr_commit;
      if (wr_commit) begin
        wr_channel <= wr_tgt;
        wr_data    <= sample_in;
      end
      if (tick && wr_hit) begin
        last_wr <= wr_tgt;
        if ((wr_blocked || tgt_full) && overrun_cnt != 8'hFF) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (reset) begin
        fill[i] <= '0;
      end else if (drain_done && drain_channel == 4'(i)) begin
        fill[i] <= '0;
      end else if (wr_commit && wr_tgt == 4'(i) && fill[i] != FILL_FULL) begin
        fill[i] <= fill[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= D_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      D_IDLE:  if (gnt_hit) state_next = D_XFER;
      D_XFER:  if (drain_done) state_next = D_IDLE;
      default: state_next = D_IDLE;
    endcase
  end

  always_comb begin
    drain_valid = (state == D_XFER);
    drain_last  = (drain_index == IDX_LAST);
  end

  // Index returns to 0 on the final beat so drain_last never lingers while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_channel <= '0;
      drain_index   <= '0;
      last_gnt      <= CH_LAST;
    end else if (state == D_IDLE) begin
      if (gnt_hit) begin
        drain_channel <= gnt_tgt;
        last_gnt      <= gnt_tgt;
        drain_index   <= '0;
      end
    end else if (drain_ready) begin
      drain_index <= drain_done ? '0 : drain_index + 4'd1;
    end
  end

endmodule

// File: tb/tb_channel_sample_sequencer.sv
// tb/tb_channel_sample_sequencer.sv - randomized bench with behavioural model of the sequencer
// Model tracks fills, write pointer and drain progress as plain integers.
module tb_channel_sample_sequencer;

  localparam int NC  = 14;
  localparam int DEP = 10;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset, enable, drain_ready;
  logic [7:0]    sample_in;
  logic [NC-1:0] ch_en;
  logic          wr_valid, drain_valid, drain_last;
  logic [3:0]    wr_channel, drain_channel, drain_index;
  logic [7:0]    wr_data, overrun_cnt;
  logic [NC-1:0] ready_mask;

  int n_checks = 0;
  int n_fail   = 0;

  channel_sample_sequencer #(.NUM_CHANNELS(NC), .SAMPLE_BITS(8), .DEPTH(DEP), .DIVIDER(DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in), .ch_en(ch_en),
    .wr_valid(wr_valid), .wr_channel(wr_channel), .wr_data(wr_data),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_channel(drain_channel),
    .drain_index(drain_index), .drain_last(drain_last), .ready_mask(ready_mask),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model state
  int  m_en_cnt = 0, m_ptr = NC - 1, m_gnt = NC - 1, m_ch = 0, m_idx = 0, m_ovr = 0;
  bit  m_busy = 0;
  int  m_fill [NC];
  bit  e_wr_valid = 0;
  int  e_wr_ch = 0, e_wr_data = 0;
  logic [NC-1:0] full0;
  bit  busy0;
  int  ch0, tgt;

  function automatic int rr(input logic [NC-1:0] mask, input int last);
    for (int k = 1; k <= NC; k++) begin
      if (mask[(last + k) % NC]) return (last + k) % NC;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] model_mask();
    logic [NC-1:0] m;
    for (int i = 0; i < NC; i++) m[i] = (m_fill[i] == DEP);
    return m;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_en_cnt = 0; m_ptr = NC - 1; m_gnt = NC - 1; m_ch = 0; m_idx = 0; m_ovr = 0;
      m_busy = 0; e_wr_valid = 0; e_wr_ch = 0; e_wr_data = 0;
      for (int i = 0; i < NC; i++) m_fill[i] = 0;
    end else begin
      full0 = model_mask();
      busy0 = m_busy;
      ch0   = m_ch;
      e_wr_valid = 0;
      if (enable) begin
        if (m_en_cnt % DIV == DIV - 1) begin
          tgt = rr(ch_en, m_ptr);
          if (tgt >= 0) begin
            m_ptr = tgt;
            if (busy0 && tgt == ch0) begin
              if (m_ovr < 255) m_ovr++;
            end else begin
              e_wr_valid = 1; e_wr_ch = tgt; e_wr_data = int'(sample_in);
              if (m_fill[tgt] == DEP) begin
                if (m_ovr < 255) m_ovr++;
              end else begin
                m_fill[tgt]++;
              end
            end
          end
        end
        m_en_cnt++;
      end
      if (!busy0) begin
        if (full0 != '0) begin
          tgt = rr(full0, m_gnt);
          m_busy = 1; m_ch = tgt; m_gnt = tgt; m_idx = 0;
        end
      end else if (drain_ready) begin
        if (m_idx == DEP - 1) begin
          m_fill[ch0] = 0;
          m_busy = 0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  // Compare process plus handshake/monitor bookkeeping
  int wr_log[$];
  int grant_log[$];
  int beats = 0;
  bit prev_dv = 0;

  always @(negedge clk) begin
    chk("wr_valid", wr_valid, e_wr_valid);
    if (e_wr_valid) begin
      chk("wr_channel", wr_channel, e_wr_ch);
      chk("wr_data", wr_data, e_wr_data);
    end
    chk("drain_valid", drain_valid, m_busy);
    if (m_busy) begin
      chk("drain_channel", drain_channel, m_ch);
      chk("drain_index", drain_index, m_idx);
      chk("drain_last", drain_last, m_idx == DEP - 1);
    end
    chk("ready_mask", ready_mask, model_mask());
    chk("overrun_cnt", overrun_cnt, m_ovr);
    if (wr_valid === 1'b1) wr_log.push_back(int'(wr_channel));
    if (drain_valid === 1'b1 && !prev_dv) grant_log.push_back(int'(drain_channel));
    if (reset) begin
      beats = 0;
    end else if (drain_valid === 1'b1 && drain_ready) begin
      beats++;
      if (drain_last === 1'b1) begin
        chk("beats_per_grant", beats, DEP);
        beats = 0;
      end
    end
    prev_dv = (drain_valid === 1'b1) && !reset;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc();
    wr_log.delete();
    grant_log.delete();
    reset = 1'b0;
  endtask

  int  first_wr, first_ch, first_data, found, got_ch;

  initial begin
    reset = 1'b1; enable = 1'b0; sample_in = '0; ch_en = '0; drain_ready = 1'b0;
    repeat (3) cyc();
    chk("reset_outputs", {wr_valid, wr_channel, wr_data, drain_valid, drain_channel,
                          drain_index, drain_last, ready_mask, overrun_cnt}, 64'd0);

    // Ramp: all channels, continuous drain
    ch_en = '1; enable = 1'b1; drain_ready = 1'b1; sample_in = 8'd0;
    do_reset();
    first_wr = 0; first_ch = -1; first_data = -1;
    for (int k = 1; k <= 570; k++) begin
      cyc();
      if (wr_valid && first_wr == 0) begin
        first_wr = k; first_ch = int'(wr_channel); first_data = int'(wr_data);
      end
      sample_in = 8'(k);
    end
    chk("first_wr_cycle", first_wr, 4);
    chk("first_wr_channel", first_ch, 0);
    chk("first_wr_data", first_data, 3);
    chk("wr_log_len", wr_log.size() >= 15, 1);
    for (int i = 0; i < 15 && i < wr_log.size(); i++) chk("wr_order_all", wr_log[i], i % NC);
    chk("grant_count", grant_log.size() >= 2, 1);
    if (grant_log.size() >= 2) begin
      chk("first_grant", grant_log[0], 0);
      chk("second_grant", grant_log[1], 1);
    end

    // Sparse mask order, then empty mask holds pointer
    ch_en = 14'h2005;
    do_reset();
    repeat (17) cyc();
    chk("sparse_len", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("sparse_0", wr_log[0], 0);
      chk("sparse_1", wr_log[1], 2);
      chk("sparse_2", wr_log[2], 13);
      chk("sparse_3", wr_log[3], 0);
    end
    ch_en = '0;
    repeat (20) cyc();
    chk("empty_mask_no_write", wr_log.size(), 4);
    ch_en = '1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc();
      if (wr_log.size() > 4) found = 1;
    end
    chk("resume_found", found, 1);
    if (found) chk("resume_channel", wr_log[4], 1);

    // Overruns: channel 3 stuck in drain, channel 5 full
    ch_en = 14'h0028; drain_ready = 1'b0;
    do_reset();
    repeat (84) cyc();
    chk("skip_no_wr_valid", wr_valid, 0);
    chk("skip_overrun", overrun_cnt, 1);
    chk("skip_drain_ch", drain_channel, 3);
    repeat (4) cyc();
    chk("full_wr_valid", wr_valid, 1);
    chk("full_wr_channel", wr_channel, 5);
    chk("full_overrun", overrun_cnt, 2);
    repeat (4 * 300) cyc();
    chk("overrun_saturate", overrun_cnt, 255);

    // Stalled drain, ready pattern 1,0,0,1
    ch_en = '1; drain_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 700; k++) begin
      cyc();
      drain_ready = (k % 4 == 0) || (k % 4 == 3);
    end
    chk("stall_grant_seen", grant_log.size() >= 1, 1);
    if (grant_log.size() >= 1) chk("stall_first_grant", grant_log[0], 0);

    // Reset mid-drain
    drain_ready = 1'b1;
    do_reset();
    found = 0;
    for (int k = 0; k < 800 && !found; k++) begin
      cyc();
      if (drain_valid && drain_index == 4'd5) found = 1;
    end
    chk("reach_index5", found, 1);
    reset = 1'b1;
    cyc();
    chk("midreset_outputs", {wr_valid, wr_channel, wr_data, drain_valid, drain_channel,
                             drain_index, drain_last, ready_mask, overrun_cnt}, 64'd0);
    reset = 1'b0;
    found = 0; got_ch = -1;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc();
      if (wr_valid) begin found = 1; got_ch = int'(wr_channel); end
    end
    chk("post_reset_write", found, 1);
    chk("post_reset_channel", got_ch, 0);

    // Randomized traffic against the model
    ch_en = NC'($urandom); enable = 1'b1;
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      cyc();
      enable      = ($urandom_range(0, 7) != 0);
      drain_ready = ($urandom_range(0, 2) != 0);
      sample_in   = 8'($urandom);
      if (k % 250 == 0) ch_en = (k % 1000 == 500) ? '0 : NC'($urandom | $urandom);
    end

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
